// File: rtl/line_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : line_scan_controller_pkg
//  Description : Shared FSM state encoding and cache-line field layout for the
//                line scan controller and the logic that drives its line mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package line_scan_controller_pkg;

  // Explicit 2-bit state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  // Cache-line field offsets for the default 4-bit tag / 32-bit data layout
  localparam int VALID_BIT = 36;
  localparam int TAG_MSB   = 35;
  localparam int TAG_LSB   = 32;
  localparam int DATA_MSB  = 31;
  localparam int LINE_W    = 37;

endpackage : line_scan_controller_pkg
`default_nettype wire

// File: rtl/line_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : line_scan_controller
//  Description : Sequentially scans eight cache lines through an external 8:1
//                mux looking for a valid line whose tag matches the request.
//                Lowest matching index wins; a full scan without a match
//                reports a miss. Response is held until the consumer accepts.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_scan_controller
  import line_scan_controller_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [TAG_W-1:0]        req_tag,
  output logic [2:0]              line_sel,
  input  logic [TAG_W+DATA_W:0]   line_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_hit,
  output logic [2:0]              rsp_index,
  output logic [DATA_W-1:0]       rsp_data
);

  // Field positions derived from the parameterised widths; they reduce to
  // the package offsets for the default layout.
  localparam int c_valid_bit = TAG_W + DATA_W;
  localparam int c_tag_msb   = TAG_W + DATA_W - 1;
  localparam int c_tag_lsb   = DATA_W;
  localparam logic [2:0] c_last_sel = 3'(NUM_LINES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TAG_W-1:0]    r_tag;
  logic [2:0]          r_line_sel;
  logic                r_rsp_hit;
  logic [2:0]          r_rsp_index;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                w_match;
  logic                w_last;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and match detection on the currently selected line
  always_comb begin
    w_state_nxt = r_state;
    w_match     = line_data[c_valid_bit] &&
                  (line_data[c_tag_msb:c_tag_lsb] == r_tag);
    w_last      = (r_line_sel == c_last_sel);
    case (r_state)
      IDLE:    if (req_valid)         w_state_nxt = SCAN;
      SCAN:    if (w_match || w_last) w_state_nxt = RESP;
      RESP:    if (rsp_ready)         w_state_nxt = IDLE;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  // Datapath: tag capture, line walk and result latching
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag       <= '0;
      r_line_sel  <= 3'd0;
      r_rsp_hit   <= 1'b0;
      r_rsp_index <= 3'd0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_tag      <= req_tag;
            r_line_sel <= 3'd0;
          end
        end
        SCAN: begin
          if (w_match) begin
            r_rsp_hit   <= 1'b1;
            r_rsp_index <= r_line_sel;
            r_rsp_data  <= line_data[DATA_W-1:0];
          end else if (w_last) begin
            // Miss: select stays on the last line, no wrap
            r_rsp_hit   <= 1'b0;
            r_rsp_index <= 3'd0;
            r_rsp_data  <= '0;
          end else begin
            r_line_sel  <= r_line_sel + 3'd1;
          end
        end
        RESP: begin
          // Select returns to line 0 together with the return to IDLE
          if (rsp_ready) r_line_sel <= 3'd0;
        end
        default: r_line_sel <= 3'd0;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign line_sel  = r_line_sel;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_index = r_rsp_index;
  assign rsp_data  = r_rsp_data;

endmodule : line_scan_controller
`default_nettype wire

// File: tb/tb_line_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_scan_controller
//  Description : Self-checking bench for line_scan_controller. Models the
//                external 8:1 line mux with an array and predicts each lookup
//                from a plain search over the line contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_scan_controller;
  import line_scan_controller_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_tag;
  logic [2:0]        line_sel;
  logic [LINE_W-1:0] line_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [2:0]        rsp_index;
  logic [31:0]       rsp_data;

  logic [LINE_W-1:0] lines [8];
  int                n_cmp;
  int                n_bad;

  line_scan_controller #(.NUM_LINES(8), .TAG_W(4), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tag   (req_tag),
    .line_sel  (line_sel),
    .line_data (line_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_index (rsp_index),
    .rsp_data  (rsp_data)
  );

  // External line mux
  assign line_data = lines[line_sel];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first valid line carrying the tag wins; otherwise a miss
  function automatic void ref_lookup(input logic [3:0] tag, output logic hit,
                                     output logic [2:0] idx, output logic [31:0] data,
                                     output int lat, output logic [2:0] last_sel);
    hit = 1'b0; idx = 3'd0; data = 32'd0; lat = 8; last_sel = 3'd7;
    for (int k = 0; k < 8; k++) begin
      if (!hit && lines[k][VALID_BIT] && lines[k][TAG_MSB:TAG_LSB] == tag) begin
        hit = 1'b1; idx = 3'(k); data = lines[k][DATA_MSB:0];
        lat = k + 1; last_sel = 3'(k);
      end
    end
  endfunction

  task automatic do_lookup(input logic [3:0] tag, input logic [3:0] tag_after,
                           input int stall, input bit noisy_ready);
    logic        e_hit;
    logic [2:0]  e_idx;
    logic [31:0] e_data;
    int          e_lat;
    logic [2:0]  e_last;
    int          n;
    ref_lookup(tag, e_hit, e_idx, e_data, e_lat, e_last);
    check_eq("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_tag   = tag;
    tick();
    req_valid = 1'b0;
    req_tag   = tag_after;
    n = 0;
    while (!rsp_valid && n < 20) begin
      check_eq("scan_line_sel", 64'(line_sel), 64'(n));
      check_eq("scan_req_ready", 64'(req_ready), 64'd0);
      rsp_ready = noisy_ready ? 1'($urandom) : 1'b0;
      tick();
      n++;
    end
    rsp_ready = 1'b0;
    check_eq("latency", 64'(n), 64'(e_lat));
    check_eq("rsp_hit", 64'(rsp_hit), 64'(e_hit));
    check_eq("rsp_index", 64'(rsp_index), 64'(e_idx));
    check_eq("rsp_data", 64'(rsp_data), 64'(e_data));
    check_eq("resp_line_sel", 64'(line_sel), 64'(e_last));
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq("stall_valid", 64'(rsp_valid), 64'd1);
      check_eq("stall_req_ready", 64'(req_ready), 64'd0);
      check_eq("stall_rsp", {27'd0, rsp_hit, rsp_index, rsp_data},
               {27'd0, e_hit, e_idx, e_data});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("done_valid", 64'(rsp_valid), 64'd0);
    check_eq("done_req_ready", 64'(req_ready), 64'd1);
    check_eq("done_line_sel", 64'(line_sel), 64'd0);
  endtask

  initial begin
    logic seen;
    int   n;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_tag = 4'd0; rsp_ready = 1'b0;
    for (int k = 0; k < 8; k++) lines[k] = '0;
    tick(); tick();
    rst_n = 1'b1;
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_line_sel", 64'(line_sel), 64'd0);
    check_eq("rst_rsp", {27'd0, rsp_hit, rsp_index, rsp_data}, 64'd0);

    // Single hit at line 3, then with a 5-cycle stall
    for (int k = 0; k < 8; k++) lines[k] = {1'b0, 4'hA, 32'(k)};
    lines[3] = {1'b1, 4'hA, 32'hDEADBEEF};
    do_lookup(4'hA, 4'hA, 0, 1'b0);
    do_lookup(4'hA, 4'hA, 5, 1'b0);

    // Full miss
    for (int k = 0; k < 8; k++) lines[k] = {1'b1, 4'h1, $urandom};
    do_lookup(4'h2, 4'h2, 1, 1'b0);

    // Priority and valid qualification
    for (int k = 0; k < 8; k++) lines[k] = {1'b1, 4'h3, $urandom};
    lines[1] = {1'b0, 4'h7, 32'h11111111};
    lines[2] = {1'b1, 4'h7, 32'h22222222};
    lines[5] = {1'b1, 4'h7, 32'h55555555};
    do_lookup(4'h7, 4'h7, 0, 1'b0);

    // Tag changed after accept must not affect the scan
    for (int k = 0; k < 8; k++) lines[k] = '0;
    lines[1] = {1'b1, 4'hB, 32'hBBBB0001};
    lines[4] = {1'b1, 4'hA, 32'hAAAA0004};
    do_lookup(4'hA, 4'hB, 0, 1'b0);

    // Reset while line_sel = 4 aborts the lookup
    for (int k = 0; k < 8; k++) lines[k] = '0;
    req_valid = 1'b1; req_tag = 4'h5;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (line_sel != 3'd4 && n < 20) begin tick(); n++; end
    check_eq("abort_reach_sel4", 64'(line_sel), 64'd4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("abort_line_sel", 64'(line_sel), 64'd0);
    check_eq("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("abort_req_ready", 64'(req_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | rsp_valid;
      tick();
    end
    check_eq("abort_no_rsp", 64'(seen), 64'd0);

    // Randomised lookups with stray rsp_ready during the scan
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 8; k++)
        lines[k] = {1'($urandom), 4'($urandom_range(0, 5)), $urandom};
      do_lookup(4'($urandom_range(0, 5)), 4'($urandom), $urandom_range(0, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_line_scan_controller
`default_nettype wire

// File: doc/line_scan_controller.md
LINE_SCAN_CONTROLLER -- requirements
Module: line_scan_controller

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8, number of cache lines scanned; fixed at 8 to match the 3-bit line select.
REQ-002 SHALL have parameter TAG_W, default 4, tag field width.
REQ-003 SHALL have parameter DATA_W, default 32, data field width; LINE_W = 1 + TAG_W + DATA_W = 37.
REQ-004 Line format: bit [36] valid; bits [35:32] tag; bits [31:0] data.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 req_valid  input  1  lookup request present.
REQ-009 req_ready  output  1  controller can accept a request.
REQ-010 req_tag  input  TAG_W  tag to look up, sampled on accept.
REQ-011 line_sel  output  3  select driven to the external 8:1 line mux.
REQ-012 line_data  input  LINE_W  mux output; combinational function of line_sel in the same cycle.
REQ-013 rsp_valid  output  1  lookup result present.
REQ-014 rsp_ready  input  1  consumer accepts the result.
REQ-015 rsp_hit  output  1  1 = tag found in a valid line.
REQ-016 rsp_index  output  3  index of the matching line.
REQ-017 rsp_data  output  DATA_W  data field of the matching line.

Function
REQ-018 FSM states are IDLE, SCAN and RESP; all outputs are registered or decoded from registered state only.
REQ-019 req_ready = 1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready; the accept latches req_tag, sets line_sel = 0 and moves to SCAN.
REQ-020 Each SCAN cycle compares line_data against the latched tag.
REQ-021 Match condition: line_data[36] == 1 && line_data[35:32] == tag.
REQ-022 On a match at index k: latch rsp_hit = 1, rsp_index = k and rsp_data = line_data[31:0], then go to RESP.
REQ-023 No match and line_sel < 7: line_sel increments by 1 and the FSM stays in SCAN.
REQ-024 No match and line_sel == 7: latch rsp_hit = 0, rsp_index = 0 and rsp_data = 0, then go to RESP; line_sel does not wrap.
REQ-025 The lowest matching index wins; the scan terminates at the first match.
REQ-026 Latency: a hit at index k gives rsp_valid high k+1 edges after the accept edge; a miss gives rsp_valid high 8 edges after it.
REQ-027 RESP holds rsp_valid = 1 and all rsp_* outputs stable until the edge with rsp_ready = 1, then returns to IDLE with rsp_valid = 0.
REQ-028 A new request is accepted no earlier than the cycle after the response handshake; there is no back-to-back bypass.
REQ-029 In IDLE, line_sel = 0; in RESP, line_sel holds its last scanned value.
REQ-030 req_tag changes after accept SHALL NOT affect the scan in progress.
REQ-031 rsp_ready asserted outside RESP is ignored.

Reset
REQ-032 While rst_n = 0 at a rising edge, the FSM goes to IDLE and outputs reset to line_sel = 0, rsp_valid = 0, rsp_hit = 0, rsp_index = 0, rsp_data = 0; req_ready = 1 in the first cycle after reset.
REQ-033 Reset during SCAN or RESP aborts the lookup; no response is emitted for it.

Structure
REQ-034 A shared package holds the state enum (IDLE/SCAN/RESP), the line field offsets (VALID_BIT = 36, TAG_MSB = 35, TAG_LSB = 32, DATA_MSB = 31) and LINE_W.
REQ-035 The 8:1 line mux stays external (instantiated beside this block); no sub-module is required inside.

Verification
REQ-036 Single hit: lines 0-2 invalid; line 3 = {1, 4'hA, 32'hDEADBEEF}; req_tag = 4'hA -> rsp_valid 4 edges after accept with rsp_hit = 1, rsp_index = 3, rsp_data = 32'hDEADBEEF.
REQ-037 Miss: all lines valid, tag 4'h1; req_tag = 4'h2 -> line_sel goes 0..7, then rsp_valid after 8 edges with rsp_hit = 0, rsp_index = 0, rsp_data = 0.
REQ-038 Priority and valid check: lines 2 and 5 both tag 4'h7 and valid, line 1 tag 4'h7 but invalid -> rsp_index = 2.
REQ-039 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready = 0 throughout; rsp_ready = 1 -> IDLE next edge, req_ready = 1.
REQ-040 Reset mid-scan: rst_n = 0 while line_sel = 4 -> next edge IDLE, line_sel = 0, rsp_valid = 0, and no response for the aborted lookup.
REQ-041 Tag change: req_tag changed from 4'hA to 4'hB on the cycle after accept -> the result reflects 4'hA.
